mem_access_ctrl: RTL

Parametrised, handshaked successor to the single-cycle memory control path. It accepts one instruction at a time (opcode plus operands) and, for LDR/STR, runs a req/ack transaction with a variable-latency memory, including a wait-state timeout. It then presents write-back data and a one-cycle reg_write/done strobe to the register file. It sits between the decode/ALU stage and the memory port; while idle it drives the PC as the fetch address.

---
 rtl/mem_ctrl_pkg.sv | 25 ++
 rtl/mem_access_ctrl_if.sv | 26 ++
 rtl/mem_ctrl_wait_timer.sv | 35 +++
 rtl/mem_access_ctrl.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory access controller: opcodes, FSM encoding
// and the reg_write decode used by both this block and the decode stage.
package mem_ctrl_pkg;

    localparam logic [3:0] OP_LDR = 4'b1101;
    localparam logic [3:0] OP_STR = 4'b1110;
    localparam logic [3:0] OP_CMP = 4'b1011;
    localparam logic [3:0] OP_NOP = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_LDR) || (op == OP_STR);
    endfunction

    // Everything except compare, store and no-op writes the register file.
    function automatic logic rw_decode(input logic [3:0] op);
        return !((op == OP_CMP) || (op == OP_STR) || (op == OP_NOP));
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Memory port between the access controller (master) and a variable-latency
// memory (slave).
interface mem_access_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16
);
    // mem_req rises with mem_addr/mem_we/mem_wdata stable and holds them until
    // the cycle mem_ack=1 is sampled (or the master times out); mem_rdata is
    // only meaningful in the cycle mem_ack=1, and mem_ack without mem_req is ignored.
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_ctrl_wait_timer.sv
// Wait-state counter: cleared by clr, advances on en, saturates and flags
// expired once it has counted TIMEOUT-1 wait cycles.
module mem_ctrl_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign expired = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/mem_access_ctrl.sv
// Memory access controller: single-instruction LDR/STR req/ack sequencer with
// wait-state timeout. Optional macro ADDR_RANGE_CHECK_EN rejects out-of-range addresses.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 16,
    parameter int PC_W    = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [3:0]        op_code,
    input  logic [PC_W-1:0]   pc,
    input  logic [DATA_W-1:0] src1,
    input  logic [DATA_W-1:0] src2,
    input  logic [DATA_W-1:0] alu_result,
    output logic              busy,
    output logic              done,
    output logic              reg_write,
    output logic [DATA_W-1:0] wb_data,
    output logic              err,
    output state_t            dbg_state,
    mem_access_ctrl_if.master mem_if
);
    state_t            state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic              busy_q, busy_d, done_q, done_d, rw_q, rw_d, err_q, err_d;
    logic              req_q, req_d, we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wb_q, wb_d, wdata_q, wdata_d;
    logic              timer_expired;
    logic              addr_oob;

`ifdef ADDR_RANGE_CHECK_EN
    assign addr_oob = |(src1 >> ADDR_W);
`else
    logic src1_hi_unused;
    assign src1_hi_unused = |(src1 >> ADDR_W);
    assign addr_oob = 1'b0;
`endif

    mem_ctrl_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (state_q != ST_REQ),
        .en      ((state_q == ST_REQ) && !mem_if.mem_ack),
        .expired (timer_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_NOP;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rw_q    <= 1'b0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wb_q    <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rw_q    <= rw_d;
            err_q   <= err_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wb_q    <= wb_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (is_mem_op(op_code) && !addr_oob) ? ST_REQ : ST_DONE;
                end
            end
            ST_REQ: begin
                if (mem_if.mem_ack || timer_expired) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        op_d    = op_q;
        busy_d  = (state_d != ST_IDLE);
        done_d  = 1'b0;
        rw_d    = 1'b0;
        err_d   = 1'b0;
        req_d   = 1'b0;
        we_d    = we_q;
        addr_d  = ADDR_W'(pc);
        wb_d    = wb_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d = op_code;
                    if (is_mem_op(op_code)) begin
                        if (addr_oob) begin
                            done_d = 1'b1;
                            err_d  = 1'b1;
                        end else begin
                            req_d  = 1'b1;
                            we_d   = (op_code == OP_STR);
                            addr_d = src1[ADDR_W-1:0];
                            if (op_code == OP_STR) begin
                                wdata_d = src2;
                            end
                        end
                    end else begin
                        done_d = 1'b1;
                        rw_d   = rw_decode(op_code);
                        wb_d   = alu_result;
                    end
                end
            end
            ST_REQ: begin
                // An ack in the expiry cycle still completes normally.
                if (mem_if.mem_ack) begin
                    done_d = 1'b1;
                    rw_d   = rw_decode(op_q);
                    if (!we_q) begin
                        wb_d = mem_if.mem_rdata;
                    end
                end else if (timer_expired) begin
                    done_d = 1'b1;
                    err_d  = 1'b1;
                end else begin
                    req_d  = 1'b1;
                    addr_d = addr_q;
                end
            end
            default: ;
        endcase
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign reg_write        = rw_q;
    assign err              = err_q;
    assign wb_data          = wb_q;
    assign dbg_state        = state_q;
    assign mem_if.mem_req   = req_q;
    assign mem_if.mem_we    = we_q;
    assign mem_if.mem_addr  = addr_q;
    assign mem_if.mem_wdata = wdata_q;
endmodule
